// File: rtl/sprite_arb_pkg.sv
// Shared types for the sprite ROM arbiter: requester id, lock FSM state and return tag.
package sprite_arb_pkg;

  localparam int unsigned NumReq = 4;
  localparam int unsigned IdW    = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef logic [IdW-1:0] req_id_t;

  typedef enum logic {
    IDLE,
    BURST
  } arb_state_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  function automatic req_id_t next_id(req_id_t id);
    return (id == req_id_t'(NumReq - 1)) ? '0 : id + req_id_t'(1);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: first asserted request at or above ptr_i, wrapping around.
module rr_priority_pick
  import sprite_arb_pkg::*;
#(
  parameter int unsigned NumIn = NumReq
) (
  input  logic [NumIn-1:0] req_i,
  input  req_id_t          ptr_i,
  output logic [NumIn-1:0] gnt_o,
  output req_id_t          id_o,
  output logic             any_o
);

  always_comb begin
    int unsigned idx;
    idx   = 0;
    gnt_o = '0;
    id_o  = '0;
    any_o = 1'b0;
    for (int unsigned k = 0; k < NumIn; k++) begin
      idx = (32'(ptr_i) + k) % NumIn;
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = req_id_t'(idx);
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one pipelined sprite/palette ROM among NUM_REQ requesters, one read per cycle,
// with round-robin fairness, bounded lock bursts and a tag pipeline to route pixels back.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = NumReq,
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned ROM_LAT   = 2,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                      pixel_clk_in,
  input  logic                      rst_n_in,
  input  logic [NUM_REQ-1:0]        req_in,
  input  logic [NUM_REQ-1:0]        lock_in,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
  input  logic                      frame_start_in,
  output logic [NUM_REQ-1:0]        gnt_out,
  output logic [ADDR_W-1:0]         rom_addr_out,
  output logic                      rom_en_out,
  input  logic [DATA_W-1:0]         rom_data_in,
  output logic [NUM_REQ-1:0]        rd_valid_out,
  output logic [DATA_W-1:0]         rd_data_out
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST);

  // req_id_t is sized from the package, so the instance must agree with it.
  if (NUM_REQ != NumReq) begin : g_bad_cfg
    $error("NUM_REQ must equal sprite_arb_pkg::NumReq");
  end

  arb_state_t          state_q, state_d;
  req_id_t             ptr_q, ptr_d, owner_q, owner_d, base;
  logic [CntW-1:0]     count_q, count_d;
  logic [NUM_REQ-1:0]  pick_gnt;
  req_id_t             pick_id;
  logic                pick_any, exhausted, burst_hold;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                rom_en_q;
  tag_t                tag_q [ROM_LAT];
  tag_t                tag_d, tag_last;
  logic [NUM_REQ-1:0]  rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  // During a live burst the base is the owner itself, so the picker returns the owner
  // while it still requests; an exhausted burst starts one past the owner.
  always_comb begin
    exhausted  = (state_q == BURST) && (count_q == CntMax);
    burst_hold = (state_q == BURST) && !exhausted && req_in[owner_q] && lock_in[owner_q];
    if (state_q == BURST) begin
      base = exhausted ? next_id(owner_q) : owner_q;
    end else begin
      base = ptr_q;
    end
  end

  rr_priority_pick #(
    .NumIn(NUM_REQ)
  ) u_pick (
    .req_i(req_in),
    .ptr_i(base),
    .gnt_o(pick_gnt),
    .id_o (pick_id),
    .any_o(pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    count_d = count_q;
    if (burst_hold) begin
      count_d = count_q + CntW'(1);
    end else if (pick_any) begin
      if (lock_in[pick_id]) begin
        state_d = BURST;
        owner_d = pick_id;
        count_d = CntW'(1);
      end else begin
        state_d = IDLE;
        ptr_d   = next_id(pick_id);
        count_d = '0;
      end
    end else begin
      state_d = IDLE;
      count_d = '0;
    end
    if (frame_start_in) begin
      state_d = IDLE;
      ptr_d   = '0;
      count_d = '0;
    end
  end

  always_comb begin
    rom_addr_d = pick_any ? addr_in[32'(pick_id) * ADDR_W +: ADDR_W] : rom_addr_q;
    tag_d      = '{valid: pick_any, id: pick_id};
    tag_last   = tag_q[ROM_LAT-1];
    rd_valid_d = tag_last.valid ? (NUM_REQ'(1) << tag_last.id) : '0;
    rd_data_d  = tag_last.valid ? rom_data_in : rd_data_q;
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      count_q    <= '0;
      rom_addr_q <= '0;
      rom_en_q   <= 1'b0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      for (int i = 0; i < int'(ROM_LAT); i++) tag_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      count_q    <= count_d;
      rom_addr_q <= rom_addr_d;
      rom_en_q   <= pick_any;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      tag_q[0]   <= tag_d;
      for (int i = 1; i < int'(ROM_LAT); i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign gnt_out      = pick_gnt & {NUM_REQ{rst_n_in}};
  assign rom_addr_out = rom_addr_q;
  assign rom_en_out   = rom_en_q;
  assign rd_valid_out = rd_valid_q;
  assign rd_data_out  = rd_data_q;

endmodule
